// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with saturating counters: same-cycle next-PC lookup for IF and training/redirect from MEM.
// Optional performance counters are built when PERF_CNT_EN is defined.
module branch_target_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    input  logic              flush_all,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_branches,
    output logic [CNT_W-1:0]  perf_mispredicts,
    output logic [CNT_W-1:0]  perf_hits
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(4);
    localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
        return (c == CTR_MAX) ? c : c + CTR_W'(1);
    endfunction

    function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
        return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] jmp_q;
    logic [CTR_W-1:0]   ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];

    logic              mispredict_q, mispredict_d;
    logic [ADDR_W-1:0] redirect_q, redirect_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;
    logic             up_train;
    logic             wr_en, wr_tgt, wr_jmp;
    logic [CTR_W-1:0] ctr_d;

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{if_pc[1:0], upd_pc[1:0]};

    // Lookup: reads pre-edge contents, so a same-cycle update is not bypassed.
    always_comb begin
        lk_idx       = if_pc[IDX_W+1:2];
        lk_tag       = if_pc[ADDR_W-1:IDX_W+2];
        pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken   = pred_hit && (jmp_q[lk_idx] || ctr_q[lk_idx][CTR_W-1]);
        pred_next_pc = pred_taken ? tgt_q[lk_idx] : if_pc + PC_INC;
    end

    always_comb begin
        up_idx   = upd_pc[IDX_W+1:2];
        up_tag   = upd_pc[ADDR_W-1:IDX_W+2];
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_train = upd_valid && !flush_all;
        wr_en    = 1'b0;
        wr_tgt   = 1'b0;
        wr_jmp   = jmp_q[up_idx];
        ctr_d    = ctr_q[up_idx];
        if (up_train && up_hit) begin
            wr_en = 1'b1;
            if (upd_is_jump) begin
                wr_tgt = 1'b1;
                wr_jmp = 1'b1;
                ctr_d  = CTR_MAX;
            end else if (upd_taken) begin
                wr_tgt = 1'b1;
                ctr_d  = ctr_inc(ctr_q[up_idx]);
            end else if (!jmp_q[up_idx]) begin
                ctr_d  = ctr_dec(ctr_q[up_idx]);
            end
        end else if (up_train && upd_taken) begin
            wr_en  = 1'b1;
            wr_tgt = 1'b1;
            wr_jmp = upd_is_jump;
            ctr_d  = upd_is_jump ? CTR_MAX : CTR_WEAK;
        end
    end

    // Mispredict is evaluated even when a flush suppresses training.
    always_comb begin
        mispredict_d = upd_valid && ((upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));
        redirect_d   = redirect_q;
        if (mispredict_d) begin
            redirect_d = upd_taken ? upd_target : upd_pc + PC_INC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            jmp_q        <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= '0;
            end
        end else begin
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            if (flush_all) begin
                valid_q <= '0;
            end else if (wr_en) begin
                valid_q[up_idx] <= 1'b1;
                jmp_q[up_idx]   <= wr_jmp;
                ctr_q[up_idx]   <= ctr_d;
            end
        end
    end

    // Tag/target payload needs no reset; valid_q gates its use.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            tag_q[up_idx] <= up_tag;
            if (wr_tgt) begin
                tgt_q[up_idx] <= upd_target;
            end
        end
    end

    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_q;

`ifdef PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] perf_br_q, perf_br_d;
    logic [CNT_W-1:0] perf_mp_q, perf_mp_d;
    logic [CNT_W-1:0] perf_hit_q, perf_hit_d;

    always_comb begin
        perf_br_d  = upd_valid              ? cnt_inc(perf_br_q)  : perf_br_q;
        perf_mp_d  = mispredict_d           ? cnt_inc(perf_mp_q)  : perf_mp_q;
        perf_hit_d = (upd_valid && up_hit)  ? cnt_inc(perf_hit_q) : perf_hit_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_q  <= '0;
            perf_mp_q  <= '0;
            perf_hit_q <= '0;
        end else begin
            perf_br_q  <= perf_br_d;
            perf_mp_q  <= perf_mp_d;
            perf_hit_q <= perf_hit_d;
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mp_q;
    assign perf_hits        = perf_hit_q;
`endif

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised branch/jump predictor for the 5-stage pipelined MIPS core. Replaces the fixed jump-offset fix-up and resolve-in-MEM branch handling.
- IF stage queries a direct-mapped branch target buffer (BTB) with saturating counters and gets a same-cycle next-PC prediction.
- MEM stage reports resolved outcomes. The block trains itself and raises a registered one-cycle mispredict/redirect to flush IF/ID and ID/EX.

Parameters:
ADDR_W, 32, PC/target width in bits
ENTRIES, 16, BTB entries; power of two, >= 2
CTR_W, 2, saturating counter width, >= 1
CNT_W, 32, performance counter width (PERF_CNT_EN only)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
if_pc  input  ADDR_W  PC being fetched
pred_hit  output  1  BTB tag hit for if_pc (combinational)
pred_taken  output  1  predicted taken (combinational)
pred_next_pc  output  ADDR_W  predicted next PC (combinational)
upd_valid  input  1  resolved control-flow instruction this cycle
upd_pc  input  ADDR_W  PC of the resolved instruction
upd_is_jump  input  1  unconditional jump
upd_taken  input  1  actual outcome
upd_target  input  ADDR_W  actual target
upd_pred_taken  input  1  prediction carried down the pipe
upd_pred_target  input  ADDR_W  predicted target carried down the pipe
flush_all  input  1  synchronous invalidate of all entries
mispredict  output  1  registered one-cycle redirect request
redirect_pc  output  ADDR_W  correct next PC, valid while mispredict=1

Behaviour:
- IDX_W = log2(ENTRIES).
  - index = pc[IDX_W+1:2]
  - tag = pc[ADDR_W-1:IDX_W+2]
- Entry fields: valid, tag, target, ctr[CTR_W-1:0], jmp.
- Lookup (combinational):
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && (jmp || ctr MSB).
  - pred_next_pc = pred_taken ? target : if_pc+4, modulo 2^ADDR_W.
- Update (posedge, upd_valid=1, flush_all=0):
  - Hit, conditional branch: ctr saturating +1 if taken, -1 if not. Target overwritten only when taken.
  - Hit, jump: jmp=1, ctr=all ones, target overwritten. Jump entries are never decremented.
  - Miss, taken: allocate and overwrite any previous occupant. Set valid=1, tag, target, jmp=upd_is_jump. ctr = all ones for a jump, 1<<(CTR_W-1) (weakly taken) for a branch.
  - Miss, not taken: no allocation, no state change.
- mispredict (registered): asserts the cycle after upd_valid when either:
  - upd_pred_taken != upd_taken, or
  - both taken and upd_pred_target != upd_target.
  redirect_pc = upd_taken ? upd_target : upd_pc+4. mispredict is 0 in every other cycle. redirect_pc holds its last value when mispredict=0.
- Lookup and update to the same index in the same cycle: the lookup sees pre-edge contents. The write is visible from the next cycle.
- flush_all:
  - Clears all valid bits at the next edge.
  - If upd_valid is also set, flush wins and nothing is allocated or trained. Mispredict is still evaluated and reported.
- Reset (async, rst_n=0):
  - All valid=0, ctr=0, jmp=0.
  - mispredict=0, redirect_pc=0, all counters 0.
  - With the table empty: pred_hit=0, pred_taken=0, pred_next_pc=if_pc+4.
  - Reset asserted mid-update discards the update. Deassertion is synchronous to clk, handled by the top-level synchroniser.

Optional Feature:
PERF_CNT_EN
- Defined:
  - Adds outputs perf_branches, perf_mispredicts, perf_hits, each CNT_W bits.
  - perf_branches counts upd_valid cycles.
  - perf_mispredicts counts mispredict pulses.
  - perf_hits counts resolved updates whose upd_pc hit the table before the edge.
  - All three saturate at all ones, reset to 0, and are not cleared by flush_all.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then if_pc=0x40 → pred_hit=0, pred_taken=0, pred_next_pc=0x44. mispredict=0.
- Update upd_pc=0x40, taken, target 0x100, upd_pred_taken=0 → next cycle mispredict=1, redirect_pc=0x100. Following cycle mispredict=0. Lookup 0x40 → hit, taken, next_pc=0x100.
- Counter hysteresis, same branch: one not-taken update (ctr 10→01) → lookup 0x40 predicts not-taken, next_pc=0x44. Then one taken update → predicts taken again. Then three taken updates → ctr saturates at 11 and one not-taken still predicts taken.
- Aliasing: with 0x40 resident, taken update at 0x80 (same index 0, tag 2) → 0x80 hits with its own target. Lookup 0x40 → pred_hit=0.
- Jump upd_pc=0x200, target 0x300, upd_is_jump=1, followed by five not-taken-flagged updates → lookup 0x200 still predicts taken to 0x300. Simultaneous flush_all+upd_valid → lookup 0x200 misses next cycle.
- With PERF_CNT_EN defined: run 10 updates containing 3 mispredicts → perf_branches=10, perf_mispredicts=3. Assert rst_n=0 mid-stream → all counters read 0 immediately (asynchronous).
